// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the slice-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_BITS_DEFAULT = 4;

endpackage

// File: rtl/serial_adder_ctrl_adder_nbit.sv
// Plain ripple N-bit adder slice with carry in/out; the only adder in the block.
module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = a + b + {{N{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Adds two TOTAL_BITS operands one SLICE_BITS slice per cycle through a single
// shared adder_nbit, then presents a registered sum/overflow with a done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int TOTAL_BITS = 16,
  parameter int SLICE_BITS = SLICE_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [TOTAL_BITS-1:0] sum,
  output logic                  overflow
);

  localparam int N  = TOTAL_BITS / SLICE_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  generate
    if (TOTAL_BITS % SLICE_BITS != 0) begin : g_bad_width
      $error("TOTAL_BITS must be a multiple of SLICE_BITS");
    end
  endgenerate

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] a_q, a_d;
  logic [TOTAL_BITS-1:0] b_q, b_d;
  logic [TOTAL_BITS-1:0] res_q, res_d;
  logic                  carry_q, carry_d;
  logic [TOTAL_BITS-1:0] sum_q, sum_d;
  logic                  ovf_q, ovf_d;

  logic [SLICE_BITS-1:0] slice_sum;
  logic                  slice_cout;

  adder_nbit #(.N(SLICE_BITS)) u_slice (
    .a    (a_q[SLICE_BITS-1:0]),
    .b    (b_q[SLICE_BITS-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Result fills from the top so the first slice ends up in the LSBs.
        a_d     = a_q >> SLICE_BITS;
        b_d     = b_q >> SLICE_BITS;
        res_d   = (res_q >> SLICE_BITS) |
                  (TOTAL_BITS'(slice_sum) << (TOTAL_BITS - SLICE_BITS));
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
          sum_d   = res_d;
          ovf_d   = slice_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule
